// File: rtl/permute_gather_pipe_pkg.sv
// Shared parameters and helpers for the read-side lane gather.
// P and MAP normally come from the datapath parameter set; the defaults give 4 lanes with 2-bit tags.
`ifndef P
`define P 2
`endif
`ifndef MAP
`define MAP 2
`endif

package permute_gather_pipe_pkg;

  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/permute_gather_pipe_perm_map_fifo.sv
// Holds each request's destination map until its bank response returns.
// ovf/udf are registered one-cycle pulses. A push into an empty FIFO is never bypassed to a same-cycle pop.
module perm_map_fifo
  import permute_gather_pipe_pkg::*;
#(
  parameter int DW    = 9,
  parameter int DEPTH = 4,
  parameter int LW    = level_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [DW-1:0] i_data,
  output logic [DW-1:0] o_head,
  output logic          o_pop_ok,
  output logic          o_ovf,
  output logic          o_udf,
  output logic [LW-1:0] o_level
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_ovf;
  logic          r_udf;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == LW'(DEPTH));
  assign w_pop   = i_pop && !w_empty;
  // At full, a push only fits when the head leaves in the same cycle.
  assign w_push  = i_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
      r_ovf <= i_push && w_full && !w_pop;
      r_udf <= i_pop && w_empty;
    end
  end

  assign o_head   = r_mem[r_rd_ptr];
  assign o_pop_ok = w_pop;
  assign o_ovf    = r_ovf;
  assign o_udf    = r_udf;
  assign o_level  = r_level;

endmodule

// File: rtl/permute_gather_pipe.sv
// Returns bank-ordered read data to lane order: out lane i = bank slot dest[i].
// Maps are queued at request time, checked for being a permutation, and applied when the response arrives.
module permute_gather_pipe
  import permute_gather_pipe_pkg::*;
#(
  parameter int N     = 2 * `P,
  parameter int W     = 1,
  parameter int SELW  = `MAP,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_req_valid,
  input  logic [N*SELW-1:0]              i_req_dest_bus,
  input  logic                           i_rsp_valid,
  input  logic [N*W-1:0]                 i_rsp_bus,
  output logic                           o_out_valid,
  output logic [N*W-1:0]                 o_out_bus,
  output logic                           o_out_map_err,
  output logic                           o_ovf_err,
  output logic                           o_udf_err,
  output logic [level_width(DEPTH)-1:0]  o_fifo_level
);

  localparam int LW = level_width(DEPTH);
  localparam int DW = N * SELW + 1;

  logic              w_bad;
  logic [DW-1:0]     w_head;
  logic [N*SELW-1:0] w_head_map;
  logic              w_head_bad;
  logic              w_pop_ok;
  logic [N*W-1:0]    w_gather;

  logic              r_out_valid;
  logic [N*W-1:0]    r_out_bus;
  logic              r_out_map_err;

  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (32'(i_req_dest_bus[i*SELW +: SELW]) >= N) w_bad = 1'b1;
      for (int j = i + 1; j < N; j++) begin
        if (i_req_dest_bus[i*SELW +: SELW] == i_req_dest_bus[j*SELW +: SELW]) w_bad = 1'b1;
      end
    end
  end

  perm_map_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .LW    (LW)
  ) u_map_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_push   (i_req_valid),
    .i_pop    (i_rsp_valid),
    .i_data   ({w_bad, i_req_dest_bus}),
    .o_head   (w_head),
    .o_pop_ok (w_pop_ok),
    .o_ovf    (o_ovf_err),
    .o_udf    (o_udf_err),
    .o_level  (o_fifo_level)
  );

  assign w_head_map = w_head[N*SELW-1:0];
  assign w_head_bad = w_head[DW-1];

  // Out-of-range tags match no slot and leave the lane at zero.
  always_comb begin
    w_gather = '0;
    for (int i = 0; i < N; i++) begin
      for (int b = 0; b < N; b++) begin
        if (32'(w_head_map[i*SELW +: SELW]) == b) w_gather[i*W +: W] = i_rsp_bus[b*W +: W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid   <= 1'b0;
      r_out_bus     <= '0;
      r_out_map_err <= 1'b0;
    end else begin
      r_out_valid <= w_pop_ok;
      if (w_pop_ok) begin
        r_out_bus     <= w_gather;
        r_out_map_err <= w_head_bad;
      end
    end
  end

  assign o_out_valid   = r_out_valid;
  assign o_out_bus     = r_out_bus;
  assign o_out_map_err = r_out_map_err;

endmodule

// File: tb/tb_permute_gather_pipe.sv
// Directed bench for permute_gather_pipe with N=4, W=8, SELW=2, DEPTH=4.
module tb_permute_gather_pipe;

  localparam int N = 4, W = 8, SELW = 2, DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [7:0]  req_dest_bus = '0;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_bus = '0;
  logic        out_valid;
  logic [31:0] out_bus;
  logic        out_map_err;
  logic        ovf_err;
  logic        udf_err;
  logic [2:0]  fifo_level;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  permute_gather_pipe #(.N(N), .W(W), .SELW(SELW), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_req_valid    (req_valid),
    .i_req_dest_bus (req_dest_bus),
    .i_rsp_valid    (rsp_valid),
    .i_rsp_bus      (rsp_bus),
    .o_out_valid    (out_valid),
    .o_out_bus      (out_bus),
    .o_out_map_err  (out_map_err),
    .o_ovf_err      (ovf_err),
    .o_udf_err      (udf_err),
    .o_fifo_level   (fifo_level)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mk_map(input int t0, input int t1, input int t2, input int t3);
    logic [1:0] a, b, c, d;
    a = t0[1:0]; b = t1[1:0]; c = t2[1:0]; d = t3[1:0];
    return {d, c, b, a};
  endfunction

  function automatic logic [31:0] mk_data(input logic [7:0] s0, input logic [7:0] s1,
                                          input logic [7:0] s2, input logic [7:0] s3);
    return {s3, s2, s1, s0};
  endfunction

  function automatic logic [31:0] gather(input logic [7:0] m, input logic [31:0] d);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*8 +: 8] = d[int'(m[i*2 +: 2])*8 +: 8];
    return r;
  endfunction

  // Inputs are driven at the falling edge; outputs are read at the next falling edge.
  task automatic cyc(input logic rq, input logic [7:0] m, input logic rs, input logic [31:0] d);
    req_valid = rq; req_dest_bus = m; rsp_valid = rs; rsp_bus = d;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; rsp_valid = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [31:0] exp_bus, input logic exp_err);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_bus"}, out_bus, exp_bus);
    check({tag, "_err"}, {31'd0, out_map_err}, {31'd0, exp_err});
  endtask

  logic [31:0] d10;
  logic [7:0]  q[$];
  logic [7:0]  m_rand;
  logic [31:0] d_rand;
  logic [31:0] exp_bus;
  int          lvl;

  initial begin
    d10 = mk_data(8'h10, 8'h11, 8'h12, 8'h13);
    repeat (2) @(negedge clk);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_bus", out_bus, 32'd0);
    check("rst_err", {29'd0, out_map_err, ovf_err, udf_err}, 32'd0);
    check("rst_level", {29'd0, fifo_level}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // identity map, response two cycles after the request
    cyc(1'b1, mk_map(0, 1, 2, 3), 1'b0, '0);
    check("id_level", {29'd0, fifo_level}, 32'd1);
    cyc(1'b0, '0, 1'b0, '0);
    cyc(1'b0, '0, 1'b1, mk_data(8'hA0, 8'hB1, 8'hC2, 8'hD3));
    check_out("id", mk_data(8'hA0, 8'hB1, 8'hC2, 8'hD3), 1'b0);
    check("id_level0", {29'd0, fifo_level}, 32'd0);

    cyc(1'b1, mk_map(2, 0, 3, 1), 1'b0, '0);
    cyc(1'b0, '0, 1'b0, '0);
    cyc(1'b0, '0, 1'b1, d10);
    check_out("perm", mk_data(8'h12, 8'h10, 8'h13, 8'h11), 1'b0);

    cyc(1'b1, mk_map(1, 1, 2, 3), 1'b0, '0);
    cyc(1'b0, '0, 1'b0, '0);
    cyc(1'b0, '0, 1'b1, d10);
    check_out("dup", mk_data(8'h11, 8'h11, 8'h12, 8'h13), 1'b1);

    cyc(1'b0, '0, 1'b0, 32'hFFFF_FFFF);
    check("hold_valid", {31'd0, out_valid}, 32'd0);
    check("hold_bus", out_bus, mk_data(8'h11, 8'h11, 8'h12, 8'h13));

    // fill, overflow, push+pop at full, then drain in order
    cyc(1'b1, mk_map(0, 1, 2, 3), 1'b0, '0);
    cyc(1'b1, mk_map(1, 2, 3, 0), 1'b0, '0);
    cyc(1'b1, mk_map(3, 2, 1, 0), 1'b0, '0);
    cyc(1'b1, mk_map(0, 0, 0, 0), 1'b0, '0);
    check("full_level", {29'd0, fifo_level}, 32'd4);
    check("full_noovf", {31'd0, ovf_err}, 32'd0);
    cyc(1'b1, mk_map(3, 3, 3, 3), 1'b0, '0);
    check("ovf_pulse", {31'd0, ovf_err}, 32'd1);
    check("ovf_level", {29'd0, fifo_level}, 32'd4);
    check("ovf_novalid", {31'd0, out_valid}, 32'd0);
    cyc(1'b1, mk_map(2, 3, 0, 1), 1'b1, d10);
    check_out("fullpp", mk_data(8'h10, 8'h11, 8'h12, 8'h13), 1'b0);
    check("fullpp_ovf", {31'd0, ovf_err}, 32'd0);
    check("fullpp_level", {29'd0, fifo_level}, 32'd4);
    cyc(1'b0, '0, 1'b1, d10);
    check_out("drain1", mk_data(8'h11, 8'h12, 8'h13, 8'h10), 1'b0);
    cyc(1'b0, '0, 1'b1, d10);
    check_out("drain2", mk_data(8'h13, 8'h12, 8'h11, 8'h10), 1'b0);
    cyc(1'b0, '0, 1'b1, d10);
    check_out("drain3", mk_data(8'h10, 8'h10, 8'h10, 8'h10), 1'b1);
    cyc(1'b0, '0, 1'b1, d10);
    check_out("drain4", mk_data(8'h12, 8'h13, 8'h10, 8'h11), 1'b0);
    check("drain_level", {29'd0, fifo_level}, 32'd0);

    // underflow, alone and with a same-cycle push
    cyc(1'b0, '0, 1'b1, d10);
    check("udf_pulse", {31'd0, udf_err}, 32'd1);
    check("udf_novalid", {31'd0, out_valid}, 32'd0);
    check("udf_level", {29'd0, fifo_level}, 32'd0);
    cyc(1'b1, mk_map(3, 2, 1, 0), 1'b1, d10);
    check("udfpush_pulse", {31'd0, udf_err}, 32'd1);
    check("udfpush_novalid", {31'd0, out_valid}, 32'd0);
    check("udfpush_level", {29'd0, fifo_level}, 32'd1);
    cyc(1'b0, '0, 1'b1, d10);
    check_out("udfpush_pop", mk_data(8'h13, 8'h12, 8'h11, 8'h10), 1'b0);
    check("udf_clear", {31'd0, udf_err}, 32'd0);

    // streaming random permutations, responses two cycles behind requests
    lvl = 0;
    for (int k = 0; k < 22; k++) begin
      logic rq, rs;
      logic [1:0] p[4];
      rq = (k < 20);
      rs = (k >= 2);
      m_rand = '0;
      if (rq) begin
        for (int i = 0; i < 4; i++) p[i] = 2'(i);
        for (int i = 3; i > 0; i--) begin
          int j;
          logic [1:0] t;
          j = int'($urandom_range(i, 0));
          t = p[i]; p[i] = p[j]; p[j] = t;
        end
        m_rand = {p[3], p[2], p[1], p[0]};
        q.push_back(m_rand);
        lvl++;
      end
      d_rand = $urandom;
      exp_bus = '0;
      if (rs) begin
        exp_bus = gather(q.pop_front(), d_rand);
        lvl--;
      end
      cyc(rq, m_rand, rs, d_rand);
      check("stream_valid", {31'd0, out_valid}, {31'd0, rs});
      if (rs) begin
        check("stream_bus", out_bus, exp_bus);
        check("stream_err", {31'd0, out_map_err}, 32'd0);
      end
      check("stream_flags", {30'd0, ovf_err, udf_err}, 32'd0);
      check("stream_level", {29'd0, fifo_level}, 32'(lvl));
    end

    // asynchronous reset with maps pending
    cyc(1'b1, mk_map(1, 0, 3, 2), 1'b0, '0);
    cyc(1'b1, mk_map(0, 1, 2, 3), 1'b0, '0);
    cyc(1'b1, mk_map(0, 1, 2, 3), 1'b1, d10);
    check_out("pre_rst", mk_data(8'h11, 8'h10, 8'h13, 8'h12), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_valid", {31'd0, out_valid}, 32'd0);
    check("mrst_bus", out_bus, 32'd0);
    check("mrst_flags", {29'd0, out_map_err, ovf_err, udf_err}, 32'd0);
    check("mrst_level", {29'd0, fifo_level}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cyc(1'b0, '0, 1'b1, d10);
    check("post_rst_udf", {31'd0, udf_err}, 32'd1);
    check("post_rst_novalid", {31'd0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/permute_gather_pipe.md
Name: permute_gather_pipe

Overview:
- Read-side counterpart of the lane-to-bank scatter permutation in the multi-lane NTT datapath.
- The write path scatters lane i to bank dest[i]. On the read back, this block returns bank data to lane order: out lane i = bank slot dest[i].
- A small FIFO holds each read request's destination map until the bank response arrives after the memory latency. The block applies the gather and registers the result.
- It also checks that every map is a true permutation and flags FIFO overflow and underflow.

Parameters:
- N, 2*`P, number of lanes/banks.
- W, 1, data width per lane.
- SELW, `MAP, width of one destination tag.
- DEPTH, 4, map FIFO depth (power of 2, >= memory read latency + 1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  read request issued this cycle; push the map
- req_dest_bus  in  N*SELW  map used by the request; tag i in bits [i*SELW +: SELW]
- rsp_valid  in  1  bank response present this cycle; pop the map
- rsp_bus  in  N*W  bank-ordered response data; slot b in bits [b*W +: W]
- out_valid  out  1  gathered lane-ordered data valid
- out_bus  out  N*W  lane-ordered data
- out_map_err  out  1  map of the current output entry was not a permutation (qualified by out_valid)
- ovf_err  out  1  one-cycle pulse: push dropped because the FIFO was full
- udf_err  out  1  one-cycle pulse: response arrived with the FIFO empty
- fifo_level  out  $clog2(DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset (async assert, sync deassert handled upstream) clears:
  - out_valid=0, out_bus=0, out_map_err=0, ovf_err=0, udf_err=0, fifo_level=0.
  - Read/write pointers to 0.
  - FIFO contents need not be cleared.
- Push (req_valid=1):
  - Map check is combinational on req_dest_bus: bad=1 if any tag >= N or any two tags are equal.
  - The map and the bad bit are stored together as one FIFO entry.
- Pop (rsp_valid=1 and level>0):
  - Head entry is read.
  - Next cycle: out_valid=1; out_bus lane i = rsp_bus slot map[i] (a tag >= N yields 0 for that lane); out_map_err = stored bad bit.
  - Latency rsp_valid -> out_valid is exactly 1 cycle; throughput is 1 per cycle.
- No backpressure. Output regs update every cycle:
  - out_valid=0 on cycles without a successful pop.
  - out_bus holds its last value while out_valid=0.
- Occupancy/status rules (evaluated on the start-of-cycle level):
  - Push and pop in the same cycle, level>0: both occur; level unchanged, including at level=DEPTH.
  - Push, no pop, level=DEPTH: entry dropped, ovf_err=1 next cycle, state unchanged.
  - Pop with level=0: no output, udf_err=1 next cycle. A simultaneous push is still stored (no bypass), so level goes to 1.
- Pointers wrap modulo DEPTH; level saturates at neither end, because the rules above prevent it.
- Reset mid-stream discards all pending maps; the first rsp_valid after reset with no pushes raises udf_err.
- Widths: index compare uses SELW bits against N as an integer; out_bus lane mux is N-way per lane.

Decomposition:
- Shared parameter include (already used by the datapath) supplies `P and `MAP. No new package constants except a localparam for the level width.
- One natural sub-module, perm_map_fifo: a DEPTH x (N*SELW+1) FIFO with push/pop, level, ovf/udf pulses.
- Gather mux and permutation check stay in the top level.

Test Plan (N=4, W=8, SELW=2, DEPTH=4):
- Identity map [0,1,2,3] pushed; 2 cycles later rsp_bus slots [A0,B1,C2,D3] -> next cycle out_valid=1, lanes [A0,B1,C2,D3], out_map_err=0.
- Map lanes->banks [2,0,3,1]; rsp slots [10,11,12,13] -> lanes [12,10,13,11], out_map_err=0.
- Duplicate map [1,1,2,3]; rsp [10,11,12,13] -> lanes [11,11,12,13], out_map_err=1.
- Push 4 maps back-to-back, then push a 5th with no pop -> ovf_err pulse, fifo_level stays 4. Then 4 pops return outputs in push order.
- rsp_valid with an empty FIFO -> udf_err pulse, out_valid=0. Same-cycle push + rsp at empty -> udf_err and fifo_level=1.
- Continuous push/pop every cycle for 20 cycles with a 2-cycle offset and random permutations -> every output matches the scoreboard, no errors. Assert rst_n mid-stream -> all outputs 0 and fifo_level=0 immediately.
